mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath (pc, im, gpr, alu, exti, dm, mux2).
- Replaces the single-cycle combinational decoder with a Moore-style FSM that splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps.
- Adds a ready handshake on data memory, a memory-wait watchdog, and a sticky trap for illegal opcodes and memory timeouts.

Parameters:
- MAX_WAIT, 15, last wait-cycle index in MEM before a timeout trap; range 0..255.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low.
- op  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0] from the instruction register.
- dm_ready  input  1  data memory has completed the current access.
- pc_write  output  1  PC loads npc (pc+4).
- ir_write  output  1  instruction register loads im output.
- reg_write  output  1  gpr write enable.
- mem_write  output  1  dm write request.
- mem_read  output  1  dm read request.
- RegDst  output  1  1 selects rd, 0 selects rt.
- ALUSrc  output  1  1 selects ime32, 0 selects b.
- MemtoReg  output  1  1 selects dm data_out for write-back.
- extiop  output  1  1 sign-extends, 0 zero-extends.
- aluop  output  5  alu operation code.
- state  output  3  current FSM state.
- trap_cause  output  2  00 none, 01 illegal instruction, 10 memory timeout.
- instret  output  32  count of retired instructions (see Optional Feature).

Behaviour:
- State encoding: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Codes 6 and unused values go to INIT.
- While reset=0: state=INIT, all outputs 0, wait counter=0, trap_cause=00, instret=0. This applies immediately, including mid-instruction.
- INIT: all strobes 0; next state FETCH.
- FETCH: ir_write=1, pc_write=1 for exactly one cycle; next state DECODE.
- DECODE: all strobes 0.
  - Legal op/funct goes to EXEC.
  - Illegal op/funct goes to TRAP with trap_cause=01.
- Decode table (R-type is op=000000, keyed by funct; all R-type use RegDst=1, ALUSrc=0, extiop=0):
  - add 100000: aluop 00000.
  - addu 100001: aluop 00001.
  - subu 100011: aluop 00010.
  - and 100100: aluop 00011.
  - or 100101: aluop 00100.
  - slt 101010: aluop 00101.
- Decode table, I-type (all use RegDst=0, ALUSrc=1):
  - addi 001000: extiop=1, aluop 00000.
  - addiu 001001: extiop=1, aluop 00001.
  - andi 001100: extiop=0, aluop 00011.
  - ori 001101: extiop=0, aluop 00100.
  - lui 001111: extiop=1, aluop 01010.
  - lw 100011: extiop=1, aluop 00000, MemtoReg=1.
  - sw 101011: extiop=1, aluop 00000.
- Any other op/funct is illegal.
- Datapath selects (RegDst, ALUSrc, extiop, aluop, MemtoReg) are driven from the table in EXEC, MEM and WB. They are 0 in INIT, FETCH, DECODE and TRAP, and held stable across EXEC..WB.
- EXEC: strobes 0; lw/sw go to MEM, all others go to WB.
- MEM:
  - Wait counter is cleared on entry and increments each cycle dm_ready=0.
  - sw: mem_write=1 every MEM cycle; dm_ready=1 goes to FETCH (retire).
  - lw: mem_read=1 every MEM cycle; dm_ready=1 goes to WB.
  - dm_ready=0 with counter==MAX_WAIT goes to TRAP with trap_cause=10; the strobe drops next cycle.
  - dm_ready=1 on the timeout cycle wins over the timeout.
- WB: reg_write=1 for exactly one cycle; next state FETCH (retire).
- TRAP: all strobes 0, state sticky until reset; trap_cause holds its value.
- Latency, FETCH to next FETCH: ALU ops 4 cycles; sw 4+W; lw 5+W, where W = dm_ready wait cycles.
- gpr ignores writes to register 0; the controller does not special-case it.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: instret is a 32-bit counter that increments on each retire (WB→FETCH or sw MEM→FETCH), wraps 0xFFFFFFFF→0, and clears on reset.
- Undefined: instret is tied to 0 and no counter logic exists. The port is always present.

Test Plan:
- Reset release, op=000000 funct=100001 (addu), dm_ready=1 → states 0,1,2,3,5,1. reg_write high only in state 5 with RegDst=1, aluop=00001. pc_write/ir_write high only in state 1.
- lw (op=100011), dm_ready=0 for 3 cycles then 1 → mem_read high 4 cycles, then WB with MemtoReg=1, reg_write=1. FETCH→FETCH = 8 cycles.
- sw (op=101011), dm_ready=1 → mem_write high exactly 1 cycle, reg_write never high, ALUSrc=1, extiop=1, next FETCH after MEM.
- op=000010 → TRAP the cycle after DECODE, trap_cause=01, no pc_write/ir_write for 20 further cycles.
- sw with dm_ready stuck 0, MAX_WAIT=15 → mem_write high 16 cycles, then state=7, trap_cause=10; pulse reset → state=0, trap_cause=00.
- reset asserted mid-lw in MEM → all outputs 0 immediately. With PERF_CNT_EN, 3 retired addu → instret=3, then reset → 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore control sequencer for the MIPS-subset datapath.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module mc_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        dm_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        mem_write,
   output logic        mem_read,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        extiop,
   output logic [4:0]  aluop,
   output logic [2:0]  state,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       extiop;
      logic [4:0] aluop;
      logic       is_lw;
      logic       is_sw;
   } ctrl_t;

   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   state_t     r_state;
   state_t     w_next;
   ctrl_t      r_ctrl;
   ctrl_t      w_dec;
   logic       w_legal;
   logic [7:0] r_wait;
   logic [1:0] r_trap;
   logic       w_timeout;

   assign state      = r_state;
   assign trap_cause = r_trap;
   assign w_timeout  = (r_state == S_MEM) && !dm_ready && (r_wait == LP_MAX_WAIT);

   // Instruction decode table; only consulted in DECODE, then frozen in r_ctrl.
   always_comb begin
      w_dec   = '0;
      w_legal = 1'b0;
      case (op)
         6'b000000: begin
            w_dec.regdst = 1'b1;
            w_legal      = 1'b1;
            case (funct)
               6'b100000: w_dec.aluop = 5'b00000;
               6'b100001: w_dec.aluop = 5'b00001;
               6'b100011: w_dec.aluop = 5'b00010;
               6'b100100: w_dec.aluop = 5'b00011;
               6'b100101: w_dec.aluop = 5'b00100;
               6'b101010: w_dec.aluop = 5'b00101;
               default:   w_legal     = 1'b0;
            endcase
         end
         6'b001000: begin
            w_legal = 1'b1; w_dec.alusrc = 1'b1; w_dec.extiop = 1'b1; w_dec.aluop = 5'b00000;
         end
         6'b001001: begin
            w_legal = 1'b1; w_dec.alusrc = 1'b1; w_dec.extiop = 1'b1; w_dec.aluop = 5'b00001;
         end
         6'b001100: begin
            w_legal = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 5'b00011;
         end
         6'b001101: begin
            w_legal = 1'b1; w_dec.alusrc = 1'b1; w_dec.aluop = 5'b00100;
         end
         6'b001111: begin
            w_legal = 1'b1; w_dec.alusrc = 1'b1; w_dec.extiop = 1'b1; w_dec.aluop = 5'b01010;
         end
         6'b100011: begin
            w_legal = 1'b1; w_dec.alusrc = 1'b1; w_dec.extiop = 1'b1;
            w_dec.memtoreg = 1'b1; w_dec.is_lw = 1'b1;
         end
         6'b101011: begin
            w_legal = 1'b1; w_dec.alusrc = 1'b1; w_dec.extiop = 1'b1; w_dec.is_sw = 1'b1;
         end
         default: w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_INIT;
         r_ctrl  <= '0;
         r_wait  <= '0;
         r_trap  <= 2'b00;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_ctrl <= w_dec;
            if (!w_legal) r_trap <= 2'b01;
         end
         if (r_state == S_EXEC) begin
            r_wait <= '0;
         end else if (r_state == S_MEM && !dm_ready) begin
            r_wait <= r_wait + 8'd1;
         end
         if (w_timeout) r_trap <= 2'b10;
      end
   end

   // Next-state and Moore outputs; selects only live in EXEC..WB.
   always_comb begin
      w_next    = r_state;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      RegDst    = 1'b0;
      ALUSrc    = 1'b0;
      MemtoReg  = 1'b0;
      extiop    = 1'b0;
      aluop     = 5'b00000;
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
         RegDst   = r_ctrl.regdst;
         ALUSrc   = r_ctrl.alusrc;
         MemtoReg = r_ctrl.memtoreg;
         extiop   = r_ctrl.extiop;
         aluop    = r_ctrl.aluop;
      end
      case (r_state)
         S_INIT:   w_next = S_FETCH;
         S_FETCH: begin
            pc_write = 1'b1;
            ir_write = 1'b1;
            w_next   = S_DECODE;
         end
         S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
         S_EXEC:   w_next = (r_ctrl.is_lw || r_ctrl.is_sw) ? S_MEM : S_WB;
         S_MEM: begin
            mem_write = r_ctrl.is_sw;
            mem_read  = r_ctrl.is_lw;
            if (dm_ready)       w_next = r_ctrl.is_lw ? S_WB : S_FETCH;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_WB: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
         end
         S_TRAP:   w_next = S_TRAP;
         default:  w_next = S_INIT;
      endcase
   end

`ifdef PERF_CNT_EN
   logic        w_retire;
   logic [31:0] r_instret;

   assign w_retire = (r_state == S_WB) || (r_state == S_MEM && r_ctrl.is_sw && dm_ready);
   assign instret  = r_instret;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_instret <= '0;
      else if (w_retire) r_instret <= r_instret + 32'd1;
   end
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: expands each instruction into its expected per-cycle
// output trace from the latency/decode rules and compares every cycle.
module tb_mc_ctrl;
   localparam int MAXW = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  op = '0;
   logic [5:0]  funct = '0;
   logic        dm_ready = 1'b1;
   logic        pc_write, ir_write, reg_write, mem_write, mem_read;
   logic        RegDst, ALUSrc, MemtoReg, extiop;
   logic [4:0]  aluop;
   logic [2:0]  state;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   mc_ctrl #(.MAX_WAIT(MAXW)) dut (
      .clock(clock), .reset(reset), .op(op), .funct(funct), .dm_ready(dm_ready),
      .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
      .mem_write(mem_write), .mem_read(mem_read), .RegDst(RegDst), .ALUSrc(ALUSrc),
      .MemtoReg(MemtoReg), .extiop(extiop), .aluop(aluop), .state(state),
      .trap_cause(trap_cause), .instret(instret)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [5:0] op;
      logic [5:0] funct;
      logic       legal;
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       extiop;
      logic [4:0] aluop;
      logic [1:0] kind;   // 0 alu, 1 lw, 2 sw
   } ins_t;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        rdy;
      logic [2:0]  st;
      logic [13:0] ctl;
      logic [1:0]  tc;
      logic [31:0] ir;
   } cyc_t;

   cyc_t        q[$];
   int          n_checks = 0;
   int          n_err = 0;
   logic [1:0]  m_trap = 2'b00;
   logic [31:0] m_ret = '0;
   int          cyc_no = 0;
   int          last_fetch = -1;
   int          intervals[$];
   logic [31:0] fetch_ir[$];
   int          memw_cnt = 0;

   function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input logic rd,
                               input logic as, input logic m2r, input logic ex,
                               input logic [4:0] a, input logic [1:0] k);
      ins_t r;
      r.op = o; r.funct = f; r.legal = 1'b1; r.regdst = rd; r.alusrc = as;
      r.memtoreg = m2r; r.extiop = ex; r.aluop = a; r.kind = k;
      return r;
   endfunction

   // Instruction table: 0 add,1 addu,2 subu,3 and,4 or,5 slt,6 addi,7 addiu,
   // 8 andi,9 ori,10 lui,11 lw,12 sw, anything else = j (illegal).
   function automatic ins_t info(input int k);
      ins_t r;
      case (k)
         0:  r = mk(6'b000000, 6'b100000, 1, 0, 0, 0, 5'b00000, 0);
         1:  r = mk(6'b000000, 6'b100001, 1, 0, 0, 0, 5'b00001, 0);
         2:  r = mk(6'b000000, 6'b100011, 1, 0, 0, 0, 5'b00010, 0);
         3:  r = mk(6'b000000, 6'b100100, 1, 0, 0, 0, 5'b00011, 0);
         4:  r = mk(6'b000000, 6'b100101, 1, 0, 0, 0, 5'b00100, 0);
         5:  r = mk(6'b000000, 6'b101010, 1, 0, 0, 0, 5'b00101, 0);
         6:  r = mk(6'b001000, 6'b000000, 0, 1, 0, 1, 5'b00000, 0);
         7:  r = mk(6'b001001, 6'b000000, 0, 1, 0, 1, 5'b00001, 0);
         8:  r = mk(6'b001100, 6'b000000, 0, 1, 0, 0, 5'b00011, 0);
         9:  r = mk(6'b001101, 6'b000000, 0, 1, 0, 0, 5'b00100, 0);
         10: r = mk(6'b001111, 6'b000000, 0, 1, 0, 1, 5'b01010, 0);
         11: r = mk(6'b100011, 6'b000000, 0, 1, 1, 1, 5'b00000, 1);
         12: r = mk(6'b101011, 6'b000000, 0, 1, 0, 1, 5'b00000, 2);
         default: begin
            r = mk(6'b000010, 6'b000000, 0, 0, 0, 0, 5'b00000, 0);
            r.legal = 1'b0;
         end
      endcase
      return r;
   endfunction

   task automatic add(input ins_t in, input logic rdy, input logic [2:0] st,
                      input logic [4:0] stb, input logic sel_on);
      cyc_t c;
      c.op = in.op; c.funct = in.funct; c.rdy = rdy; c.st = st;
      c.ctl = {stb, sel_on ? {in.regdst, in.alusrc, in.memtoreg, in.extiop, in.aluop} : 9'b0};
      c.tc = m_trap;
`ifdef PERF_CNT_EN
      c.ir = m_ret;
`else
      c.ir = '0;
`endif
      q.push_back(c);
   endtask

   // Expand one instruction into its cycles. w = dm_ready wait cycles; w beyond
   // the watchdog limit yields the timeout trap; ntrap = trap cycles to observe.
   task automatic push_instr(input int k, input int w, input int ntrap);
      ins_t in;
      in = info(k);
      add(in, 1, 3'd1, 5'b11000, 0);
      add(in, 1, 3'd2, 5'b00000, 0);
      if (!in.legal) begin
         m_trap = 2'b01;
         repeat (ntrap) add(in, 1, 3'd7, 5'b00000, 0);
         return;
      end
      add(in, 1, 3'd3, 5'b00000, 1);
      if (in.kind != 0) begin
         if (w > MAXW) begin
            for (int i = 0; i <= MAXW; i++) add(in, 0, 3'd4, (in.kind == 1) ? 5'b00001 : 5'b00010, 1);
            m_trap = 2'b10;
            repeat (ntrap) add(in, 0, 3'd7, 5'b00000, 0);
            return;
         end
         for (int i = 0; i < w; i++) add(in, 0, 3'd4, (in.kind == 1) ? 5'b00001 : 5'b00010, 1);
         add(in, 1, 3'd4, (in.kind == 1) ? 5'b00001 : 5'b00010, 1);
         if (in.kind == 2) begin
            m_ret++;
            return;
         end
      end
      add(in, 1, 3'd5, 5'b00100, 1);
      m_ret++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [50:0] snap();
      return {state, trap_cause, pc_write, ir_write, reg_write, mem_write, mem_read,
              RegDst, ALUSrc, MemtoReg, extiop, aluop, instret};
   endfunction

   // Drives each queued cycle after the rising edge, checks it at the falling edge.
   task automatic run_trace();
      for (int i = 0; i < q.size(); i++) begin
         @(posedge clock);
         #1;
         reset = 1'b1;
         op = q[i].op; funct = q[i].funct; dm_ready = q[i].rdy;
         @(negedge clock);
         chk($sformatf("cyc%0d", cyc_no), 64'(snap()),
             64'({q[i].st, q[i].tc, q[i].ctl, q[i].ir}));
         if (state == 3'd1) begin
            if (last_fetch >= 0) intervals.push_back(cyc_no - last_fetch);
            last_fetch = cyc_no;
            fetch_ir.push_back(instret);
         end
         if (mem_write) memw_cnt++;
         cyc_no++;
      end
      q.delete();
   endtask

   task automatic model_reset();
      m_trap = 2'b00; m_ret = '0; last_fetch = -1;
   endtask

   initial begin : main
      int exp_iv[9];
      ins_t lw_in;
      exp_iv = '{4, 4, 4, 8, 4, 4, 4, 4, 6};

      // Held in reset
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_state", 64'(snap()), 64'd0);

      // ALU, load/store and illegal-opcode sequence
      model_reset();
      add(info(1), 1, 3'd0, 5'b00000, 0);
      push_instr(1, 0, 0);
      push_instr(1, 0, 0);
      push_instr(1, 0, 0);
      push_instr(11, 3, 0);
      push_instr(12, 0, 0);
      push_instr(8, 0, 0);
      push_instr(10, 0, 0);
      push_instr(5, 0, 0);
      push_instr(12, 2, 0);
      push_instr(13, 0, 20);
      run_trace();
      chk("n_intervals", 64'(intervals.size()), 64'd9);
      for (int i = 0; i < 9 && i < intervals.size(); i++)
         chk($sformatf("fetch_interval%0d", i), 64'(intervals[i]), 64'(exp_iv[i]));
`ifdef PERF_CNT_EN
      chk("instret_after_3_addu", 64'(fetch_ir[3]), 64'd3);
`else
      chk("instret_tied_0", 64'(fetch_ir[3]), 64'd0);
`endif
      chk("illegal_trap_cause", 64'(trap_cause), 64'd1);

      // Sticky trap cleared by reset
      #2 reset = 1'b0;
      #1 chk("reset_after_illegal", 64'(snap()), 64'd0);

      // Store with dm_ready stuck low hits the watchdog
      model_reset();
      memw_cnt = 0;
      add(info(12), 0, 3'd0, 5'b00000, 0);
      push_instr(12, 1000, 5);
      run_trace();
      chk("timeout_memw_cycles", 64'(memw_cnt), 64'd16);
      chk("timeout_state", 64'(state), 64'd7);
      chk("timeout_cause", 64'(trap_cause), 64'd2);
      #2 reset = 1'b0;
      #1 chk("reset_after_timeout", 64'(snap()), 64'd0);

      // Load interrupted by reset while waiting in MEM
      model_reset();
      lw_in = info(11);
      add(lw_in, 0, 3'd0, 5'b00000, 0);
      add(lw_in, 0, 3'd1, 5'b11000, 0);
      add(lw_in, 0, 3'd2, 5'b00000, 0);
      add(lw_in, 0, 3'd3, 5'b00000, 1);
      add(lw_in, 0, 3'd4, 5'b00001, 1);
      add(lw_in, 0, 3'd4, 5'b00001, 1);
      run_trace();
      chk("mid_lw_mem_read", 64'(mem_read), 64'd1);
      #2 reset = 1'b0;
      #1 chk("reset_mid_lw", 64'(snap()), 64'd0);
      @(posedge clock);
      #1 chk("reset_mid_lw_held", 64'(snap()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end
endmodule
